plic_claim_master: RTL and testbench

- APB4 initiator that services the PLIC from the hart/target side.
- On a raised PLIC interrupt line it:
  - reads the claim/complete register to claim an ID,
  - hands the ID to a software-facing handler over a valid/ready pair,
  - waits for the handler's done indication,
  - writes the same ID back to complete.
- Sits between the PLIC's APB4 slave port and a lightweight interrupt-dispatch unit or test core.

---
 rtl/plic_claim_master.sv | 155 +++++++++++++++
 tb/tb_plic_claim_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_master.sv
// APB4 initiator that claims a PLIC interrupt, hands the ID to a handler over valid/ready,
// waits for the handler's done, then writes the same ID back to complete it.
module plic_claim_master #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0]  CLAIM_OFS  = 32'h24,
    parameter int unsigned            ID_WIDTH   = 5,
    parameter int unsigned            TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  en_i,
    input  logic                  irq_i,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic                  pready_i,
    input  logic [31:0]           prdata_i,
    input  logic                  pslverr_i,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    output logic [ID_WIDTH-1:0]   id_o,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  spur_o,
    output logic                  err_o
);

    localparam int unsigned           CntW      = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0]       CntMax    = CntW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ClaimAddr = BASE_ADDR + CLAIM_OFS;

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StRdSetup  = 4'd1;
    localparam logic [3:0] StRdAccess = 4'd2;
    localparam logic [3:0] StDispatch = 4'd3;
    localparam logic [3:0] StWaitDone = 4'd4;
    localparam logic [3:0] StWrSetup  = 4'd5;
    localparam logic [3:0] StWrAccess = 4'd6;
    localparam logic [3:0] StGap      = 4'd7;

    logic [3:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                spur_q, spur_d;
    logic                err_q, err_d;
    logic                timed_out;
    logic                apb_phase, wr_phase;
    logic                unused_prdata;

    // Only the low ID_WIDTH bits of the claim register carry the ID.
    assign unused_prdata = ^prdata_i[31:ID_WIDTH];

    assign timed_out = !pready_i && (cnt_q == CntMax);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
            id_q    <= '0;
            cnt_q   <= '0;
            spur_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            spur_q  <= spur_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        spur_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (en_i && irq_i) begin
                    state_d = StRdSetup;
                    cnt_d   = '0;
                end
            end
            StRdSetup: state_d = StRdAccess;
            StRdAccess: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = StGap;
                    end else begin
                        id_d = prdata_i[ID_WIDTH-1:0];
                        if (prdata_i[ID_WIDTH-1:0] == '0) begin
                            spur_d  = 1'b1;
                            state_d = StGap;
                        end else begin
                            state_d = StDispatch;
                        end
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDispatch: begin
                if (id_ready_i) state_d = StWaitDone;
            end
            StWaitDone: begin
                // en_i is deliberately ignored: a claimed ID must always be completed.
                if (done_i) begin
                    state_d = StWrSetup;
                    cnt_d   = '0;
                end
            end
            StWrSetup: state_d = StWrAccess;
            StWrAccess: begin
                if (pready_i) begin
                    err_d   = pslverr_i;
                    state_d = StGap;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign apb_phase = (state_q == StRdSetup) || (state_q == StRdAccess) ||
                       (state_q == StWrSetup) || (state_q == StWrAccess);
    assign wr_phase  = (state_q == StWrSetup) || (state_q == StWrAccess);

    assign psel_o     = apb_phase;
    assign penable_o  = (state_q == StRdAccess) || (state_q == StWrAccess);
    assign pwrite_o   = wr_phase;
    assign paddr_o    = apb_phase ? ClaimAddr : '0;
    assign pwdata_o   = wr_phase ? 32'(id_q) : 32'h0;
    assign pstrb_o    = wr_phase ? 4'hF : 4'h0;
    assign pprot_o    = 3'b000;
    assign id_valid_o = (state_q == StDispatch);
    assign id_o       = id_q;
    assign busy_o     = (state_q != StIdle);
    assign spur_o     = spur_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// Bench for plic_claim_master: cycle table for basic/spurious/error/enable paths, plus
// hand sequences for wait states, backpressure, write timeout and async reset.
module tb_plic_claim_master;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        en_i, irq_i, pready_i, pslverr_i, id_ready_i, done_i;
    logic [31:0] prdata_i;
    logic [31:0] paddr_o, pwdata_o;
    logic [2:0]  pprot_o;
    logic        psel_o, penable_o, pwrite_o, id_valid_o, busy_o, spur_o, err_o;
    logic [3:0]  pstrb_o;
    logic [4:0]  id_o;

    plic_claim_master #(
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0000_0000),
        .CLAIM_OFS  (32'h24),
        .ID_WIDTH   (5),
        .TIMEOUT    (16)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .en_i       (en_i),
        .irq_i      (irq_i),
        .paddr_o    (paddr_o),
        .pprot_o    (pprot_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pstrb_o    (pstrb_o),
        .pready_i   (pready_i),
        .prdata_i   (prdata_i),
        .pslverr_i  (pslverr_i),
        .id_valid_o (id_valid_o),
        .id_ready_i (id_ready_i),
        .id_o       (id_o),
        .done_i     (done_i),
        .busy_o     (busy_o),
        .spur_o     (spur_o),
        .err_o      (err_o)
    );

    always #5 pclk = ~pclk;

    // Flags: {psel, penable, pwrite, id_valid, busy, spur, err}
    localparam logic [6:0] FIdle = 7'b0000000;
    localparam logic [6:0] FRdS  = 7'b1000100;
    localparam logic [6:0] FRdA  = 7'b1100100;
    localparam logic [6:0] FDisp = 7'b0001100;
    localparam logic [6:0] FWait = 7'b0000100;
    localparam logic [6:0] FWrS  = 7'b1010100;
    localparam logic [6:0] FWrA  = 7'b1110100;
    localparam logic [6:0] FGap  = 7'b0000100;
    localparam logic [6:0] FSpur = 7'b0000110;
    localparam logic [6:0] FErr  = 7'b0000101;
    localparam logic [31:0] A    = 32'h24;

    typedef struct packed {
        logic        en, irq, pready;
        logic [31:0] prdata;
        logic        pslverr, id_ready, done;
        logic [6:0]  flags;
        logic [31:0] paddr, pwdata;
        logic [3:0]  pstrb;
        logic [4:0]  id;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mkv(input logic en, input logic irq, input logic pready,
                                 input logic [31:0] prdata, input logic pslverr,
                                 input logic id_ready, input logic done, input logic [6:0] flags,
                                 input logic [31:0] paddr, input logic [31:0] pwdata,
                                 input logic [3:0] pstrb, input logic [4:0] id);
        vec_t v;
        v.en = en; v.irq = irq; v.pready = pready; v.prdata = prdata; v.pslverr = pslverr;
        v.id_ready = id_ready; v.done = done; v.flags = flags; v.paddr = paddr;
        v.pwdata = pwdata; v.pstrb = pstrb; v.id = id;
        return v;
    endfunction

    function automatic logic [79:0] outs();
        return {psel_o, penable_o, pwrite_o, id_valid_o, busy_o, spur_o, err_o,
                paddr_o, pwdata_o, pstrb_o, id_o};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    int pen_cnt;
    int acc_cnt;
    logic err_seen;

    initial begin
        presetn = 1'b0; en_i = 0; irq_i = 0; pready_i = 0; pslverr_i = 0;
        id_ready_i = 0; done_i = 0; prdata_i = '0;

        //            en irq rdy prdata      err rdy dn  flags  paddr pwdata  strb  id
        vecs[0]  = mkv(1, 1, 0, 32'h0,       0, 0, 0, FIdle, 0, 0,     4'h0, 5'd0);
        vecs[1]  = mkv(1, 1, 1, 32'h7,       0, 0, 0, FRdS,  A, 0,     4'h0, 5'd0);
        vecs[2]  = mkv(1, 1, 1, 32'h7,       0, 0, 0, FRdA,  A, 0,     4'h0, 5'd0);
        vecs[3]  = mkv(1, 0, 0, 32'h0,       0, 1, 0, FDisp, 0, 0,     4'h0, 5'd7);
        vecs[4]  = mkv(1, 0, 0, 32'h0,       0, 0, 0, FWait, 0, 0,     4'h0, 5'd7);
        vecs[5]  = mkv(1, 0, 0, 32'h0,       0, 0, 0, FWait, 0, 0,     4'h0, 5'd7);
        vecs[6]  = mkv(1, 0, 0, 32'h0,       0, 0, 1, FWait, 0, 0,     4'h0, 5'd7);
        vecs[7]  = mkv(1, 0, 1, 32'h0,       0, 0, 0, FWrS,  A, 32'h7, 4'hF, 5'd7);
        vecs[8]  = mkv(1, 0, 1, 32'h0,       0, 0, 0, FWrA,  A, 32'h7, 4'hF, 5'd7);
        vecs[9]  = mkv(1, 0, 0, 32'h0,       0, 0, 0, FGap,  0, 0,     4'h0, 5'd7);
        vecs[10] = mkv(1, 1, 0, 32'h0,       0, 0, 0, FIdle, 0, 0,     4'h0, 5'd7);
        vecs[11] = mkv(1, 1, 1, 32'hFFFF_FFE0, 0, 0, 0, FRdS, A, 0,    4'h0, 5'd7);
        vecs[12] = mkv(1, 1, 1, 32'hFFFF_FFE0, 0, 0, 0, FRdA, A, 0,    4'h0, 5'd7);
        vecs[13] = mkv(1, 0, 0, 32'h0,       0, 0, 0, FSpur, 0, 0,     4'h0, 5'd0);
        vecs[14] = mkv(1, 1, 0, 32'h0,       0, 0, 0, FIdle, 0, 0,     4'h0, 5'd0);
        vecs[15] = mkv(1, 1, 1, 32'h5,       1, 0, 0, FRdS,  A, 0,     4'h0, 5'd0);
        vecs[16] = mkv(1, 1, 1, 32'h5,       1, 0, 0, FRdA,  A, 0,     4'h0, 5'd0);
        vecs[17] = mkv(1, 0, 0, 32'h0,       0, 0, 0, FErr,  0, 0,     4'h0, 5'd0);
        vecs[18] = mkv(0, 1, 0, 32'h0,       0, 0, 0, FIdle, 0, 0,     4'h0, 5'd0);
        vecs[19] = mkv(0, 1, 0, 32'h0,       0, 0, 0, FIdle, 0, 0,     4'h0, 5'd0);

        tick();
        tick();
        check("reset_outputs", {outs(), pprot_o}, 83'h0);
        presetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tick();
            en_i = vecs[i].en; irq_i = vecs[i].irq; pready_i = vecs[i].pready;
            prdata_i = vecs[i].prdata; pslverr_i = vecs[i].pslverr;
            id_ready_i = vecs[i].id_ready; done_i = vecs[i].done;
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].flags, vecs[i].paddr, vecs[i].pwdata, vecs[i].pstrb, vecs[i].id});
        end

        // Read wait states (3 low cycles) then 5 cycles of handler backpressure.
        tick();
        en_i = 1; irq_i = 1; pready_i = 0; prdata_i = 32'h1F; pslverr_i = 0;
        done_i = 0; id_ready_i = 0; err_seen = 0;
        tick();
        check("ws_setup", {psel_o, penable_o}, 2'b10);
        pen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (penable_o) pen_cnt++;
            if (err_o) err_seen = 1;
            pready_i = (i == 3);
        end
        tick();
        pready_i = 0; irq_i = 0;
        check("ws_penable_cycles", 80'(pen_cnt), 80'd4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i), {id_valid_o, id_o, err_o}, {1'b1, 5'h1F, 1'b0});
            tick();
        end
        id_ready_i = 1;
        check("bp_accept", {id_valid_o, id_o}, {1'b1, 5'h1F});
        tick();
        id_ready_i = 0; done_i = 1;
        check("bp_wait_done", {id_valid_o, busy_o}, 2'b01);
        tick();
        done_i = 0; pready_i = 1;
        check("bp_wr_setup", {psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o},
              {3'b101, 32'h1F, 4'hF});
        tick();
        tick();
        if (err_o) err_seen = 1;
        tick();
        check("bp_idle_no_err", {busy_o, err_seen}, 2'b00);

        // en_i dropped in WAIT_DONE still completes; then the write times out.
        en_i = 1; irq_i = 1; prdata_i = 32'h3; pready_i = 1;
        tick();
        tick();
        tick();
        check("to_dispatch", {id_valid_o, id_o}, {1'b1, 5'd3});
        id_ready_i = 1;
        tick();
        id_ready_i = 0; en_i = 0; irq_i = 0;
        tick();
        tick();
        done_i = 1; pready_i = 0;
        tick();
        done_i = 0;
        check("en_off_write_issued", {psel_o, pwrite_o, pwdata_o}, {2'b11, 32'h3});
        acc_cnt = 0;
        err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!(psel_o && penable_o)) break;
            if (err_o) err_seen = 1;
            acc_cnt++;
        end
        check("to_access_cycles", 80'(acc_cnt), 80'd16);
        check("to_err_pulse", {psel_o, err_o, spur_o, err_seen}, 4'b0100);
        tick();
        check("to_err_single", {busy_o, err_o}, 2'b00);

        // Asynchronous reset in the middle of WR_ACCESS.
        en_i = 1; irq_i = 1; prdata_i = 32'h9; pready_i = 1;
        tick();
        tick();
        tick();
        id_ready_i = 1; irq_i = 0;
        tick();
        id_ready_i = 0; done_i = 1;
        tick();
        done_i = 0; pready_i = 0;
        tick();
        check("rst_in_wr_access", {psel_o, penable_o, pwrite_o, pwdata_o},
              {3'b111, 32'h9});
        #2 presetn = 1'b0;
        #1 check("rst_async_zero", {outs(), pprot_o}, 83'h0);
        tick();
        tick();
        presetn = 1'b1;
        tick();
        check("rst_release_idle", outs(), 80'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
